// File: rtl/usb_cdc_in_arbiter_if.sv
// Requester-side and CDC IN byte-stream signals of usb_cdc_in_arbiter.
// master: the arbiter itself; slave: the requesters together with the CDC IN sink.
interface usb_cdc_in_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [32*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ-1:0]    grant_o;
    logic                  busy_o;
    logic [7:0]            in_data_o;
    logic                  in_valid_o;
    logic                  in_ready_i;

    modport master (
        input  req_valid_i, req_data_i, in_ready_i,
        output req_ready_o, grant_o, busy_o, in_data_o, in_valid_o
    );

    modport slave (
        output req_valid_i, req_data_i, in_ready_i,
        input  req_ready_o, grant_o, busy_o, in_data_o, in_valid_o
    );
endinterface

// File: rtl/usb_cdc_in_arbiter.sv
// Word arbiter for the USB CDC IN byte channel: whole 32-bit words, MSB first, one idle gap per byte.
// Build option CDC_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module usb_cdc_in_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    usb_cdc_in_arbiter_if.master bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BYTE = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e             state, state_d;
    logic [31:0]        shreg, shreg_d;
    logic [1:0]         idx, idx_d;
    logic [NUM_REQ-1:0] grant, grant_d;
    logic [7:0]         in_data, in_data_d;
    logic               in_valid, in_valid_d;
    logic [NUM_REQ-1:0] win_oh;
    logic [NUM_REQ-1:0] req_ready;
    logic [31:0]        win_word;
    logic               frame_done;

    // Last byte of the word is leaving this cycle.
    assign frame_done = (state == BYTE) && bus.in_ready_i && (idx == 2'd0);

`ifdef CDC_ARB_FIXED_PRIO_EN
    always_comb begin
        win_oh = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (bus.req_valid_i[k] && (win_oh == '0)) win_oh[k] = 1'b1;
        end
    end
`else
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) grant_idx = PTR_W'(k);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)      rr_ptr <= PTR_W'(NUM_REQ - 1);
        else if (frame_done) rr_ptr <= grant_idx;
    end

    // Search starts one past the last owner, wrapping modulo NUM_REQ.
    always_comb begin
        int cand;
        win_oh = '0;
        cand   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (bus.req_valid_i[cand] && (win_oh == '0)) win_oh[cand] = 1'b1;
        end
    end
`endif

    always_comb begin
        win_word = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_oh[k]) win_word = bus.req_data_i[32*k +: 32];
        end
    end

    always_comb begin
        // NOTE: every signal written here gets its default first, so no path can infer a latch.
        state_d    = state;
        shreg_d    = shreg;
        idx_d      = idx;
        grant_d    = grant;
        in_data_d  = in_data;
        in_valid_d = in_valid;
        req_ready  = '0;
        case (state)
            IDLE: begin
                // Gated by reset so the accept strobe is low while reset is held.
                req_ready = reset_n_i ? win_oh : '0;
                if (|win_oh) begin
                    shreg_d    = win_word;
                    grant_d    = win_oh;
                    idx_d      = 2'd3;
                    in_data_d  = win_word[31:24];
                    in_valid_d = 1'b1;
                    state_d    = BYTE;
                end
            end
            BYTE: begin
                if (bus.in_ready_i) begin
                    in_valid_d = 1'b0;
                    if (idx != 2'd0) begin
                        idx_d   = idx - 2'd1;
                        shreg_d = {shreg[23:0], 8'h00};
                        state_d = GAP;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                in_data_d  = shreg[31:24];
                in_valid_d = 1'b1;
                state_d    = BYTE;
            end
            default: begin
                state_d    = IDLE;
                shreg_d    = '0;
                idx_d      = '0;
                grant_d    = '0;
                in_data_d  = '0;
                in_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= IDLE;
            shreg    <= '0;
            idx      <= '0;
            grant    <= '0;
            in_data  <= '0;
            in_valid <= 1'b0;
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            idx      <= idx_d;
            grant    <= grant_d;
            in_data  <= in_data_d;
            in_valid <= in_valid_d;
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.grant_o     = grant;
    assign bus.busy_o      = (state != IDLE);
    assign bus.in_data_o   = in_data;
    assign bus.in_valid_o  = in_valid;

endmodule

// File: tb/tb_usb_cdc_in_arbiter.sv
// Self-checking bench for usb_cdc_in_arbiter: queue-based frame model checked every cycle,
// plus directed scenarios with literal expectations (honours CDC_ARB_FIXED_PRIO_EN).
module tb_usb_cdc_in_arbiter;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    usb_cdc_in_arbiter_if #(.NUM_REQ(N)) bus ();

    usb_cdc_in_arbiter #(.NUM_REQ(N)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

`ifdef CDC_ARB_FIXED_PRIO_EN
    logic [N-1:0] exp_order [4] = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    logic [N-1:0] exp_order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model: one word = four bytes, each followed by a gap ----------------
    int         m_owner = -1;
    int         m_last  = N - 1;
    bit         m_gap   = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic [7:0] m_bytes[$];
    logic [7:0] got[$];

    function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef CDC_ARB_FIXED_PRIO_EN
        for (int j = 0; j < N; j++) if (v[j]) return j + 0 * last;
`else
        for (int j = 1; j <= N; j++) begin
            int c;
            c = (last + j) % N;
            if (v[c]) return c;
        end
`endif
        return -1;
    endfunction

    initial begin : model
        int w;
        logic [31:0] d;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1;
                m_last  = N - 1;
                m_gap   = 1'b0;
                m_data  = 8'h00;
                m_bytes.delete();
            end else if (m_owner < 0) begin
                w = pick(bus.req_valid_i, m_last);
                if (w >= 0) begin
                    d = bus.req_data_i[32*w +: 32];
                    m_bytes.delete();
                    for (int b = 3; b >= 0; b--) m_bytes.push_back(d[8*b +: 8]);
                    m_owner = w;
                    m_gap   = 1'b0;
                    m_data  = d[31:24];
                end
            end else if (m_gap) begin
                m_gap  = 1'b0;
                m_data = m_bytes[0];
            end else if (bus.in_ready_i) begin
                void'(m_bytes.pop_front());
                if (m_bytes.size() == 0) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end else begin
                    m_gap = 1'b1;
                end
            end
        end
    end

    // Log of bytes actually handed to the CDC IN sink.
    initial forever begin
        @(posedge clk);
        if (rst_n && bus.in_valid_o && bus.in_ready_i) got.push_back(bus.in_data_o);
    end

    initial begin : compare
        logic [N-1:0] eg, er;
        int w;
        forever begin
            @(posedge clk);
            #3;
            eg = '0;
            er = '0;
            if (m_owner >= 0) eg[m_owner] = 1'b1;
            else if (rst_n) begin
                w = pick(bus.req_valid_i, m_last);
                if (w >= 0) er[w] = 1'b1;
            end
            check("m_grant", 32'(bus.grant_o), 32'(eg));
            check("m_busy", 32'(bus.busy_o), 32'(m_owner >= 0));
            check("m_valid", 32'(bus.in_valid_o), 32'((m_owner >= 0) && !m_gap));
            check("m_data", 32'(bus.in_data_o), 32'(m_data));
            check("m_ready", 32'(bus.req_ready_o), 32'(er));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Presents word w on requester k and returns at the negedge after the accept edge.
    task automatic send_word(input int k, input logic [31:0] w, output int lat);
        lat = -1;
        bus.req_data_i[32*k +: 32] = w;
        bus.req_valid_i[k] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.req_ready_o[k]) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.req_valid_i[k] = 1'b0;
        check("accept_seen", 32'(lat >= 0), 32'd1);
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        for (int c = 0; c < 40 && bus.busy_o !== lvl; c++) @(negedge clk);
        check(name, 32'(bus.busy_o), 32'(lvl));
    endtask

    task automatic check_got(input string name, input logic [63:0] exp, input int n);
        check({name, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got.size()) check(name, 32'(got[i]), 32'(exp[8*(n-1-i) +: 8]));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin : stim
        logic [7:0]   t1_bytes [4];
        logic [N-1:0] order [4];
        int lat;
        int busy_seen;

        t1_bytes = '{8'hFA, 8'hB0, 8'hFA, 8'hBF};
        rst_n = 1'b0;
        bus.req_data_i  = '0;
        bus.in_ready_i  = 1'b0;
        bus.req_valid_i = '1;
        #2;
        check("rst_valid", 32'(bus.in_valid_o), 32'd0);
        check("rst_data", 32'(bus.in_data_o), 32'h00);
        check("rst_grant", 32'(bus.grant_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_ready", 32'(bus.req_ready_o), 32'd0);
        @(negedge clk);
        bus.req_valid_i = '0;
        bus.in_ready_i  = 1'b1;
        rst_n = 1'b1;

        // Single word, byte every other cycle, MSB first.
        got.delete();
        @(negedge clk);
        send_word(0, 32'hFAB0_FABF, lat);
        check("t1_accept_cycle", 32'(lat), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            check("t1_valid", 32'(bus.in_valid_o), 32'(i % 2));
            if (i % 2 == 1) check("t1_data", 32'(bus.in_data_o), 32'(t1_bytes[i/2]));
            check("t1_ready", 32'(bus.req_ready_o), 32'd0);
            check("t1_grant", 32'(bus.grant_o), 32'd1);
            @(negedge clk);
        end
        check("t1_idle_busy", 32'(bus.busy_o), 32'd0);
        check("t1_idle_grant", 32'(bus.grant_o), 32'd0);
        check_got("t1_bytes", 64'hFAB0_FABF, 4);

        // Both requesters held valid for four frames.
        reset_dut();
        bus.req_data_i  = {32'h2222_2222, 32'h1111_1111};
        bus.req_valid_i = 2'b11;
        for (int f = 0; f < 4; f++) begin
            wait_busy(1'b1, "t2_start");
            order[f] = bus.grant_o;
            if (f == 3) bus.req_valid_i = '0;
            wait_busy(1'b0, "t2_end");
        end
        for (int f = 0; f < 4; f++) check("t2_order", 32'(order[f]), 32'(exp_order[f]));

        // Five-cycle sink stall while byte 2 is offered.
        reset_dut();
        got.delete();
        send_word(0, 32'hFAB0_FABF, lat);
        repeat (2) @(negedge clk);
        check("t3_pre_data", 32'(bus.in_data_o), 32'hB0);
        bus.in_ready_i = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(bus.in_valid_o), 32'd1);
            check("t3_hold_data", 32'(bus.in_data_o), 32'hB0);
            check("t3_hold_grant", 32'(bus.grant_o), 32'd1);
        end
        bus.in_ready_i = 1'b1;
        wait_busy(1'b0, "t3_end");
        check_got("t3_bytes", 64'hFAB0_FABF, 4);

        // Requester 1 arrives mid-frame and is taken in the first idle cycle.
        reset_dut();
        got.delete();
        send_word(0, 32'hA1A2_A3A4, lat);
        bus.req_data_i[63:32] = 32'hB1B2_B3B4;
        bus.req_valid_i[1] = 1'b1;
        repeat (7) @(negedge clk);
        check("t4_idle_busy", 32'(bus.busy_o), 32'd0);
        check("t4_idle_ready", 32'(bus.req_ready_o), 32'b10);
        @(negedge clk);
        check("t4_grant", 32'(bus.grant_o), 32'b10);
        bus.req_valid_i[1] = 1'b0;
        wait_busy(1'b0, "t4_end");
        check_got("t4_bytes", 64'hA1A2_A3A4_B1B2_B3B4, 8);

        // Asynchronous reset while byte 1 is offered, then a clean frame.
        reset_dut();
        send_word(0, 32'h1234_5678, lat);
        repeat (4) @(negedge clk);
        check("t5_pre_data", 32'(bus.in_data_o), 32'h56);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(bus.in_valid_o), 32'd0);
        check("t5_rst_data", 32'(bus.in_data_o), 32'h00);
        check("t5_rst_grant", 32'(bus.grant_o), 32'd0);
        check("t5_rst_busy", 32'(bus.busy_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        send_word(0, 32'hC0DE_F00D, lat);
        wait_busy(1'b0, "t5_end");
        check_got("t5_bytes", 64'hC0DE_F00D, 4);

        // Short pulse on requester 1 while a frame is in flight leaves no trace.
        reset_dut();
        got.delete();
        send_word(0, 32'h5A5A_A5A5, lat);
        @(negedge clk);
        bus.req_data_i[63:32] = 32'hDEAD_BEEF;
        bus.req_valid_i[1] = 1'b1;
        repeat (2) @(negedge clk);
        bus.req_valid_i[1] = 1'b0;
        wait_busy(1'b0, "t6_end");
        busy_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.busy_o) busy_seen++;
        end
        check("t6_no_extra", 32'(busy_seen), 32'd0);
        check_got("t6_bytes", 64'h5A5A_A5A5, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/usb_cdc_in_arbiter.md
# usb_cdc_in_arbiter

Shares the USB CDC IN (device-to-host) byte channel between up to four 32-bit word requesters, e.g. the configuration acknowledge generator and a fabric status/debug source. It arbitrates whole words, serializes the granted word MSB first into the CDC IN ready/valid byte stream, and never interleaves bytes of different words. It sits between the word-level producers and the CDC IN port of the USB core.

## Interface
- `NUM_REQ`, 2: number of requesters. Legal range 2..4.
- `clk_i`  in  1  system clock.
- `reset_n_i`  in  1  reset: asynchronous, active-low; clock is `clk_i`.
- `req_valid_i`  in  NUM_REQ  per-requester word valid. Must hold, with data stable, until `req_ready_o` for that requester.
- `req_data_i`  in  32*NUM_REQ  requester k word at `[32*k +: 32]`.
- `req_ready_o`  out  NUM_REQ  one-hot accept. Word k is consumed at the edge where `req_valid_i[k]` and `req_ready_o[k]` are both high.
- `grant_o`  out  NUM_REQ  one-hot owner of the frame in flight; all zero when idle.
- `busy_o`  out  1  high while a frame is being serialized.
- `in_data_o`  out  8  CDC IN byte.
- `in_valid_o`  out  1  CDC IN valid.
- `in_ready_i`  in  1  CDC IN ready. A byte is consumed when `in_valid_o` and `in_ready_i` are both high.

## Operation
- State machine: IDLE, BYTE, GAP. Byte index is a 2-bit down counter, 3 to 0.
- IDLE:
  - `req_ready_o` is driven combinationally, one-hot, for the arbitration winner only when at least one `req_valid_i` bit is high.
  - On the accept edge:
    - Latch the winner's word into a 32-bit shift register.
    - Set `grant_o` to the winner.
    - Set the byte index to 3.
    - Load `in_data_o` with word[31:24] and set `in_valid_o`.
    - Go to BYTE.
- BYTE:
  - `in_valid_o` is high and `in_data_o` equals word[8*idx +: 8].
  - On a CDC handshake with idx != 0: clear `in_valid_o`, decrement idx, go to GAP.
  - On a CDC handshake with idx == 0: clear `in_valid_o` and `grant_o`, update the round-robin pointer to the granted index, go to IDLE.
  - Without a handshake, hold all outputs.
- GAP: exactly one cycle with `in_valid_o` low. Then load the next byte, set `in_valid_o`, and go to BYTE. The mandatory gap after every byte is required for correct CDC IN transfer.
- Round-robin:
  - Search order starts at pointer+1 modulo NUM_REQ.
  - Reset value of the pointer is NUM_REQ-1, so requester 0 wins first.
- `in_data_o` holds its last value while `in_valid_o` is low.
- Invalid or unreachable state: return to IDLE with all outputs cleared.

## Timing
- Reset values: `in_valid_o`=0, `in_data_o`=8'h00, `grant_o`=0, `busy_o`=0, `req_ready_o`=0, state IDLE, pointer NUM_REQ-1.
- Accept edge at cycle t. With `in_ready_i` held high:
  - Byte 3 is valid during t+1, byte 2 during t+3, byte 1 during t+5, byte 0 during t+7.
  - IDLE at t+8, where the next word can be accepted.
  - Frame period is 8 cycles.
- `busy_o` and `grant_o` are high from t+1 through the cycle in which byte 0 is consumed.
- `in_ready_i` stall: BYTE holds indefinitely. There is no timeout.
- `in_ready_i` high while `in_valid_o` is low: ignored.
- A new request during BYTE or GAP waits. It is arbitrated in the first IDLE cycle.
- Requester drops `req_valid_i` before accept: nothing latched, no side effect.
- Simultaneous requests: exactly one is accepted per IDLE cycle.
- Reset mid-frame: the frame is discarded, outputs return to reset values immediately, and the pointer resets.

## Configuration
- `CDC_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index always wins, and the round-robin pointer is not implemented.
  - Undefined (default): round-robin as described above.

## Test plan
- Single request, requester 0 word 32'hFAB0_FABF, `in_ready_i`=1: bytes FA,B0,FA,BF on cycles t+1, t+3, t+5, t+7; `in_valid_o` low on t+2, t+4, t+6; `req_ready_o[0]` pulses once, at t.
- Both requesters held valid with 32'h1111_1111 and 32'h2222_2222 for 4 frames (round-robin build): grant order 0,1,0,1. With `CDC_ARB_FIXED_PRIO_EN` defined: 0,0,0,0.
- `in_ready_i` low for 5 cycles during byte 2: `in_valid_o` and `in_data_o` hold 8'hB0 throughout the stall; no byte lost or duplicated; `grant_o` stable.
- Requester 1 raises valid during requester 0's frame: no byte interleaving; requester 1 is accepted in the first IDLE cycle after byte 0 is consumed.
- Assert `reset_n_i` during byte 1: all outputs reach reset values without a clock edge. After release, a new request on requester 0 produces its full 4-byte frame.
- `req_valid_i` pulsed high then low before any IDLE accept (requester held off by a frame in flight): no extra frame emitted.
